dualport_ram_be_clr: RTL and testbench
======================================

// Module: dualport_ram_be_clr
// PURPOSE
//  Parametrised simple dual-port RAM: one write port, one read port, one clock.
//  Adds per-byte write enables, a selectable read-during-write mode and an
//  optional output register stage. Reset starts a sequential clear engine that
//  zeroes one word per cycle instead of clearing the whole array in one cycle.
//  Used as the generic buffer memory beneath FIFOs and packet stores.
// PARAMETERS
//  RAM_WIDTH  32  data word width; must be a multiple of BYTE_W
//  RAM_DEPTH  64  number of words; need not be a power of two
//  ADDR_SIZE  6   address width; 2**ADDR_SIZE >= RAM_DEPTH
//  BYTE_W     8   bits per byte-enable lane; NBE = RAM_WIDTH/BYTE_W
//  RD_MODE    0   read-write collision: 0 = old data, 1 = new (merged) data
//  OUT_REG    0   0 = 1-cycle read latency; 1 = 2-cycle latency (extra reg)
// PORTS
//  clk       in   1          clock; all state changes on rising edge
//  rst       in   1          synchronous, active-high reset
//  write     in   1          write request, sampled at clk edge
//  wr_addr   in   ADDR_SIZE  write address
//  wr_be     in   NBE        byte enables; bit k selects data_in[k*BYTE_W +: BYTE_W]
//  data_in   in   RAM_WIDTH  write data
//  read      in   1          read request, sampled at clk edge
//  rd_addr   in   ADDR_SIZE  read address
//  data_out  out  RAM_WIDTH  read data, registered
//  rd_valid  out  1          one-cycle pulse: data_out updated by a read
//  busy      out  1          clear engine active; read and write ignored
// BEHAVIOUR
//  Reset, rst=1 at an edge: data_out<=0, rd_valid<=0, pipeline stage<=0,
//   clr_ptr<=0, state<=CLEAR, busy<=1. rst held high keeps clr_ptr at 0.
//  FSM has two states, CLEAR and IDLE.
//   CLEAR: each cycle writes 0 to mem[clr_ptr], then clr_ptr++. On the edge
//    that clears word RAM_DEPTH-1, go to IDLE and busy<=0. After rst falls,
//    busy stays high for exactly RAM_DEPTH cycles.
//   IDLE: normal operation; stays in IDLE until rst.
//  rst during CLEAR restarts the clear at word 0.
//  Memory contents are undefined until the first clear completes.
//  While busy=1: write, read and wr_be are ignored; rd_valid stays 0.
//  Write, IDLE: if write=1 and wr_addr<RAM_DEPTH, each byte lane with wr_be[k]=1
//   is updated; lanes with wr_be[k]=0 keep their value. wr_be=0 is a no-op.
//  Read, IDLE: read=1 at edge N.
//   OUT_REG=0: data_out = mem[rd_addr] and rd_valid=1 after edge N.
//   OUT_REG=1: same, after edge N+1.
//   Back-to-back reads give one result per cycle.
//  rd_valid is 0 in every cycle with no new read result.
//  data_out holds its last value when there is no read. No clear on idle.
//  rd_addr>=RAM_DEPTH: read completes with rd_valid=1 and data_out=0.
//  wr_addr>=RAM_DEPTH: write is dropped; memory is unchanged.
//  Collision (read and write, same address, same edge):
//   RD_MODE=0 returns the pre-write word.
//   RD_MODE=1 returns the merged word: new bytes where wr_be=1, old elsewhere.
//   The memory always takes the write.
//  Elaboration errors: RAM_WIDTH%BYTE_W!=0, or 2**ADDR_SIZE<RAM_DEPTH.
// TESTING
//  Defaults unless stated; each test starts with rst high 2 cycles, then low.
//  1 Reset/clear: after rst falls -> busy=1 for 64 cycles, then 0;
//    all reads of addresses 0..63 return 0; data_out=0 and rd_valid=0 meanwhile.
//  2 Byte enables: write 0xAABBCCDD be=4'hF to addr 5, then 0x11223344 be=4'b0101
//    -> read addr 5 = 0xAA22CC44; be=0 write leaves it unchanged.
//  3 Collision: mem[9]=0x0; write 0xFFFF0000 be=4'b1100 and read addr 9, same edge
//    -> RD_MODE=0 gives 0x00000000; RD_MODE=1 gives 0xFFFF0000.
//  4 Latency: burst reads of addr 0..7 holding i*3 -> rd_valid high 8 cycles;
//    data 0,3,..,21 appear 1 cycle after request (OUT_REG=0), 2 cycles (OUT_REG=1).
//  5 Reset mid-clear, RAM_DEPTH=40, ADDR_SIZE=6: pulse rst at clear cycle 20
//    -> busy lasts 40 more cycles; read addr 45 -> 0 with rd_valid=1;
//    write addr 45 -> no memory change.
//  6 Ignore while busy: write/read asserted during CLEAR -> no rd_valid;
//    the target word reads 0 after clear completes.

Source files
------------

// File: rtl/dualport_ram_be_clr.sv
// Simple dual-port RAM with byte enables, selectable read-during-write data,
// optional output register and a one-word-per-cycle clear engine started by reset.
module dualport_ram_be_clr #(
  parameter int RAM_WIDTH = 32,
  parameter int RAM_DEPTH = 64,
  parameter int ADDR_SIZE = 6,
  parameter int BYTE_W    = 8,
  parameter int RD_MODE   = 0,
  parameter int OUT_REG   = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          write,
  input  logic [ADDR_SIZE-1:0]          wr_addr,
  input  logic [RAM_WIDTH/BYTE_W-1:0]   wr_be,
  input  logic [RAM_WIDTH-1:0]          data_in,
  input  logic                          read,
  input  logic [ADDR_SIZE-1:0]          rd_addr,
  output logic [RAM_WIDTH-1:0]          data_out,
  output logic                          rd_valid,
  output logic                          busy
);

  localparam int NBE = RAM_WIDTH / BYTE_W;
  localparam int IW  = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
  localparam logic [ADDR_SIZE:0]   DEPTH_A = (ADDR_SIZE+1)'(RAM_DEPTH);
  localparam logic [ADDR_SIZE-1:0] LAST_A  = ADDR_SIZE'(RAM_DEPTH - 1);

  if (RAM_WIDTH % BYTE_W != 0) begin : g_bad_width
    $error("RAM_WIDTH must be a multiple of BYTE_W");
  end
  if ((2 ** ADDR_SIZE) < RAM_DEPTH) begin : g_bad_addr
    $error("ADDR_SIZE too small for RAM_DEPTH");
  end

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t                 state, state_nxt;
  logic [ADDR_SIZE-1:0]   clr_ptr, clr_ptr_nxt;
  logic [RAM_WIDTH-1:0]   mem [RAM_DEPTH];

  logic                   wr_ok, rd_ok, collide;
  logic [RAM_WIDTH-1:0]   rd_word;
  logic [RAM_WIDTH-1:0]   rd_data_p0;
  logic                   rd_vld_p0;

  function automatic logic [RAM_WIDTH-1:0] merge_be(
    input logic [RAM_WIDTH-1:0] old_w,
    input logic [RAM_WIDTH-1:0] new_w,
    input logic [NBE-1:0]       be
  );
    logic [RAM_WIDTH-1:0] m;
    m = old_w;
    for (int k = 0; k < NBE; k++) begin
      if (be[k]) m[k*BYTE_W +: BYTE_W] = new_w[k*BYTE_W +: BYTE_W];
    end
    return m;
  endfunction

  function automatic logic in_range(input logic [ADDR_SIZE-1:0] a);
    return {1'b0, a} < DEPTH_A;
  endfunction

  function automatic logic [IW-1:0] idx(input logic [ADDR_SIZE-1:0] a);
    return a[IW-1:0];
  endfunction

  assign busy = (state == CLEAR);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR;
      clr_ptr <= '0;
    end else begin
      state   <= state_nxt;
      clr_ptr <= clr_ptr_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    clr_ptr_nxt = clr_ptr;
    case (state)
      CLEAR: begin
        clr_ptr_nxt = clr_ptr + 1'b1;
        if (clr_ptr == LAST_A) begin
          state_nxt   = IDLE;
          clr_ptr_nxt = '0;
        end
      end
      IDLE:    state_nxt = IDLE;
      default: state_nxt = CLEAR;
    endcase
  end

  // Port qualification: nothing reaches the array or read path while clearing
  assign wr_ok   = !rst && (state == IDLE) && write && in_range(wr_addr) && (|wr_be);
  assign rd_ok   = !rst && (state == IDLE) && read;
  assign collide = wr_ok && (rd_addr == wr_addr);

  always_comb begin
    rd_word = '0;
    if (in_range(rd_addr)) begin
      rd_word = mem[idx(rd_addr)];
      if (RD_MODE == 1 && collide) rd_word = merge_be(mem[idx(rd_addr)], data_in, wr_be);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && state == CLEAR) mem[idx(clr_ptr)] <= '0;
    else if (wr_ok)             mem[idx(wr_addr)] <= merge_be(mem[idx(wr_addr)], data_in, wr_be);
  end

  // Stage p0: array read register
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_vld_p0  <= 1'b0;
      rd_data_p0 <= '0;
    end else begin
      rd_vld_p0 <= rd_ok;
      if (rd_ok) rd_data_p0 <= rd_word;
    end
  end

  // Stage p1: optional output register
  if (OUT_REG != 0) begin : g_out_reg
    logic [RAM_WIDTH-1:0] rd_data_p1;
    logic                 rd_vld_p1;
    always_ff @(posedge clk) begin
      if (rst) begin
        rd_vld_p1  <= 1'b0;
        rd_data_p1 <= '0;
      end else begin
        rd_vld_p1 <= rd_vld_p0;
        if (rd_vld_p0) rd_data_p1 <= rd_data_p0;
      end
    end
    assign data_out = rd_data_p1;
    assign rd_valid = rd_vld_p1;
  end else begin : g_no_out_reg
    assign data_out = rd_data_p0;
    assign rd_valid = rd_vld_p0;
  end

endmodule

// File: tb/tb_dualport_ram_be_clr.sv
// Directed bench for dualport_ram_be_clr: three instances (default, new-data +
// output register, 40-word depth) share the write/read ports.
module tb_dualport_ram_be_clr;

  logic        clk, rst, rst2;
  logic        write, read;
  logic [5:0]  wr_addr, rd_addr;
  logic [3:0]  wr_be;
  logic [31:0] data_in;
  logic [31:0] d0, d1, d2;
  logic        v0, v1, v2, b0, b1, b2;

  int errors = 0;
  int checks = 0;

  dualport_ram_be_clr #(.RAM_WIDTH(32), .RAM_DEPTH(64), .ADDR_SIZE(6), .BYTE_W(8),
                        .RD_MODE(0), .OUT_REG(0)) dut0 (
    .clk(clk), .rst(rst), .write(write), .wr_addr(wr_addr), .wr_be(wr_be),
    .data_in(data_in), .read(read), .rd_addr(rd_addr),
    .data_out(d0), .rd_valid(v0), .busy(b0));

  dualport_ram_be_clr #(.RAM_WIDTH(32), .RAM_DEPTH(64), .ADDR_SIZE(6), .BYTE_W(8),
                        .RD_MODE(1), .OUT_REG(1)) dut1 (
    .clk(clk), .rst(rst), .write(write), .wr_addr(wr_addr), .wr_be(wr_be),
    .data_in(data_in), .read(read), .rd_addr(rd_addr),
    .data_out(d1), .rd_valid(v1), .busy(b1));

  dualport_ram_be_clr #(.RAM_WIDTH(32), .RAM_DEPTH(40), .ADDR_SIZE(6), .BYTE_W(8),
                        .RD_MODE(0), .OUT_REG(0)) dut2 (
    .clk(clk), .rst(rst2), .write(write), .wr_addr(wr_addr), .wr_be(wr_be),
    .data_in(data_in), .read(read), .rd_addr(rd_addr),
    .data_out(d2), .rd_valid(v2), .busy(b2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d, input logic [3:0] be);
    write = 1'b1; wr_addr = a; data_in = d; wr_be = be;
    step;
    write = 1'b0;
  endtask

  task automatic rd(input logic [5:0] a);
    read = 1'b1; rd_addr = a;
    step;
    read = 1'b0;
  endtask

  int bc0, bc1, bc2, vcnt;
  logic [31:0] dor;

  initial begin
    rst = 1'b1; rst2 = 1'b1; write = 1'b0; read = 1'b0;
    wr_addr = '0; rd_addr = '0; wr_be = '0; data_in = '0;
    step; step;
    chk("rst_busy0", 32'(b0), 32'd1);
    chk("rst_valid0", 32'(v0), 32'd0);
    chk("rst_data0", d0, 32'd0);
    chk("rst_valid1", 32'(v1), 32'd0);
    chk("rst_data1", d1, 32'd0);
    chk("rst_busy2", 32'(b2), 32'd1);

    // clear phase with ignored traffic; dut2 gets a reset pulse mid-clear
    rst = 1'b0; rst2 = 1'b0;
    write = 1'b1; wr_addr = 6'd9; wr_be = 4'hF; data_in = 32'hDEADBEEF;
    read = 1'b1; rd_addr = 6'd9;
    bc0 = b0 ? 1 : 0; bc1 = b1 ? 1 : 0; bc2 = 0; vcnt = 0; dor = '0;
    for (int e = 1; e <= 80; e++) begin
      step;
      if (b0) bc0++;
      if (b1) bc1++;
      if (e >= 21 && b2) bc2++;
      if (v0 || v1 || v2) vcnt++;
      dor = dor | d0 | d1 | d2;
      if (e == 20) rst2 = 1'b1;
      if (e == 21) rst2 = 1'b0;
      if (e == 30) begin write = 1'b0; read = 1'b0; end
    end
    chk("busy_cycles0", 32'(bc0), 32'd64);
    chk("busy_cycles1", 32'(bc1), 32'd64);
    chk("busy_cycles2_after_restart", 32'(bc2), 32'd40);
    chk("valid_while_busy", 32'(vcnt), 32'd0);
    chk("data_while_busy", dor, 32'd0);
    chk("busy0_done", 32'(b0), 32'd0);
    chk("busy2_done", 32'(b2), 32'd0);

    // every word reads zero after the clear
    for (int i = 0; i < 66; i++) begin
      read = (i < 64);
      rd_addr = (i < 64) ? 6'(i) : 6'd0;
      step;
      chk("sweep_valid0", 32'(v0), 32'(i < 64));
      chk("sweep_data0", d0, 32'd0);
      chk("sweep_valid1", 32'(v1), 32'(i >= 1 && i <= 64));
      chk("sweep_data1", d1, 32'd0);
      chk("sweep_valid2", 32'(v2), 32'(i < 64));
      chk("sweep_data2", d2, 32'd0);
    end
    read = 1'b0;

    // byte enables
    wr(6'd5, 32'hAABBCCDD, 4'hF);
    wr(6'd5, 32'h11223344, 4'b0101);
    rd(6'd5);
    chk("be_merge0", d0, 32'hAA22CC44);
    chk("be_valid0", 32'(v0), 32'd1);
    chk("be_merge2", d2, 32'hAA22CC44);
    step;
    chk("be_merge1", d1, 32'hAA22CC44);
    chk("be_valid1", 32'(v1), 32'd1);
    chk("hold_valid0", 32'(v0), 32'd0);
    chk("hold_data0", d0, 32'hAA22CC44);
    wr(6'd5, 32'h99999999, 4'b0000);
    rd(6'd5);
    chk("be_zero0", d0, 32'hAA22CC44);
    step;
    chk("be_zero1", d1, 32'hAA22CC44);

    // collisions on word 9 (cleared, busy-time write must not have landed)
    rd(6'd9);
    chk("busy_write_dropped0", d0, 32'd0);
    chk("busy_write_dropped2", d2, 32'd0);
    step;
    chk("busy_write_dropped1", d1, 32'd0);
    write = 1'b1; wr_addr = 6'd9; data_in = 32'hFFFF0000; wr_be = 4'b1100;
    read = 1'b1; rd_addr = 6'd9;
    step;
    write = 1'b0; read = 1'b0;
    chk("coll_old0", d0, 32'h00000000);
    chk("coll_old2", d2, 32'h00000000);
    step;
    chk("coll_new1", d1, 32'hFFFF0000);
    write = 1'b1; wr_addr = 6'd9; data_in = 32'h12345678; wr_be = 4'b0011;
    read = 1'b1; rd_addr = 6'd9;
    step;
    write = 1'b0; read = 1'b0;
    chk("coll2_old0", d0, 32'hFFFF0000);
    step;
    chk("coll2_merged1", d1, 32'hFFFF5678);
    rd(6'd9);
    chk("coll_mem0", d0, 32'hFFFF5678);
    step;
    chk("coll_mem1", d1, 32'hFFFF5678);

    // burst read latency
    for (int i = 0; i < 8; i++) wr(6'(i), 32'(i * 3), 4'hF);
    for (int j = 0; j < 10; j++) begin
      read = (j < 8);
      rd_addr = (j < 8) ? 6'(j) : 6'd0;
      step;
      chk("burst_valid0", 32'(v0), 32'(j < 8));
      chk("burst_data0", d0, (j < 8) ? 32'(j * 3) : 32'd21);
      chk("burst_valid1", 32'(v1), 32'(j >= 1 && j <= 8));
      if (j >= 1) chk("burst_data1", d1, (j <= 8) ? 32'((j - 1) * 3) : 32'd21);
      chk("burst_valid2", 32'(v2), 32'(j < 8));
      chk("burst_data2", d2, (j < 8) ? 32'(j * 3) : 32'd21);
    end
    read = 1'b0;

    // out-of-range address on the 40-word instance
    wr(6'd45, 32'hCAFEF00D, 4'hF);
    wr(6'd39, 32'h39393939, 4'hF);
    rd(6'd45);
    chk("oor_data2", d2, 32'd0);
    chk("oor_valid2", 32'(v2), 32'd1);
    chk("inrange45_data0", d0, 32'hCAFEF00D);
    rd(6'd39);
    chk("last_word2", d2, 32'h39393939);
    rd(6'd13);
    chk("oor_no_alias2", d2, 32'd0);
    rd(6'd5);
    chk("oor_keep5_2", d2, 32'd15);

    // reset from IDLE clears outputs and restarts the clear
    rst = 1'b1;
    step;
    chk("rerst_data0", d0, 32'd0);
    chk("rerst_valid0", 32'(v0), 32'd0);
    chk("rerst_busy0", 32'(b0), 32'd1);
    chk("rerst_data1", d1, 32'd0);
    rst = 1'b0;
    step;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
